// File: rtl/regfile_mp.sv
// Multi-read-port register file with hardwired x0 and pending-write scoreboard.
// Optional write-through read bypass when RF_BYPASS_EN is defined.
module regfile_mp #(
   parameter int XLEN   = 32,
   parameter int NREGS  = 32,
   parameter int NUM_RD = 2
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [NUM_RD*$clog2(NREGS)-1:0] raddr,
   output logic [NUM_RD*XLEN-1:0] rdata,
   output logic [NUM_RD-1:0]      rbusy,
   input  logic                   RegWrite,
   input  logic [$clog2(NREGS)-1:0] RD,
   input  logic [XLEN-1:0]        WriteData,
   input  logic                   busy_set,
   input  logic [$clog2(NREGS)-1:0] busy_rd,
   output logic [NREGS-1:0]       busy_vec
);

   localparam int AW = $clog2(NREGS);

   logic [XLEN-1:0]  rf [NREGS];
   logic [NREGS-1:0] busy;
   logic [NREGS-1:0] busy_nxt;
   logic             wr_en;

   assign wr_en = RegWrite && (RD != '0);

   // Issue set is applied after writeback clear so a same-register pair ends pending.
   always_comb begin
      busy_nxt = busy;
      if (RegWrite)
         busy_nxt[RD] = 1'b0;
      if (busy_set)
         busy_nxt[busy_rd] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++)
            rf[i] <= '0;
         busy <= '0;
      end else begin
         if (wr_en)
            rf[RD] <= WriteData;
         busy <= busy_nxt;
      end
   end

   assign busy_vec = busy;

   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic [AW-1:0] addr;
      logic          hit;

      assign addr = raddr[p*AW +: AW];

`ifdef RF_BYPASS_EN
      assign hit = wr_en && (addr == RD);
`else
      assign hit = 1'b0;
`endif

      assign rdata[p*XLEN +: XLEN] = (addr == '0) ? '0 :
                                     hit ? WriteData : rf[addr];
      // A forwarded result is no longer pending unless re-issued this cycle.
      assign rbusy[p] = hit ? (busy_set && (busy_rd == addr)) : busy[addr];
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed plus randomized bench for regfile_mp against an array-based model.
// Checks bypass behaviour according to whether RF_BYPASS_EN is defined.
module tb_regfile_mp;

   localparam int XLEN   = 32;
   localparam int NREGS  = 32;
   localparam int NUM_RD = 3;
   localparam int AW     = 5;

   logic                   clock = 1'b0;
   logic                   reset;
   logic [NUM_RD*AW-1:0]   raddr;
   logic [NUM_RD*XLEN-1:0] rdata;
   logic [NUM_RD-1:0]      rbusy;
   logic                   RegWrite;
   logic [AW-1:0]          RD;
   logic [XLEN-1:0]        WriteData;
   logic                   busy_set;
   logic [AW-1:0]          busy_rd;
   logic [NREGS-1:0]       busy_vec;

   int checks   = 0;
   int failures = 0;

   logic [XLEN-1:0] m_rf   [NREGS];
   bit              m_busy [NREGS];

   regfile_mp #(
      .XLEN  (XLEN),
      .NREGS (NREGS),
      .NUM_RD(NUM_RD)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .raddr    (raddr),
      .rdata    (rdata),
      .rbusy    (rbusy),
      .RegWrite (RegWrite),
      .RD       (RD),
      .WriteData(WriteData),
      .busy_set (busy_set),
      .busy_rd  (busy_rd),
      .busy_vec (busy_vec)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < NREGS; i++) begin
         m_rf[i]   = '0;
         m_busy[i] = 1'b0;
      end
   endtask

   function automatic logic [31:0] exp_data(input int a);
      if (a == 0) return '0;
`ifdef RF_BYPASS_EN
      if (!reset && RegWrite && RD != 0 && int'(RD) == a) return WriteData;
`endif
      return m_rf[a];
   endfunction

   function automatic logic exp_busy(input int a);
`ifdef RF_BYPASS_EN
      if (!reset && RegWrite && RD != 0 && int'(RD) == a)
         return busy_set && int'(busy_rd) == a;
`endif
      return m_busy[a];
   endfunction

   function automatic logic [31:0] exp_vec();
      logic [31:0] v;
      for (int i = 0; i < NREGS; i++) v[i] = m_busy[i];
      return v;
   endfunction

   task automatic check_all(input string tag);
      for (int p = 0; p < NUM_RD; p++) begin
         int a;
         a = int'(raddr[p*AW +: AW]);
         chk({tag, "_rdata"}, rdata[p*XLEN +: XLEN], exp_data(a));
         chk({tag, "_rbusy"}, 32'(rbusy[p]), 32'(exp_busy(a)));
      end
      chk({tag, "_busy_vec"}, busy_vec, exp_vec());
   endtask

   // Edge semantics: data write skips x0; clear then set, so set wins.
   task automatic tick();
      if (!reset) begin
         if (RegWrite && RD != 0) m_rf[RD] = WriteData;
         if (RegWrite) m_busy[RD] = 1'b0;
         if (busy_set && busy_rd != 0) m_busy[busy_rd] = 1'b1;
      end
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      RegWrite = 1'b0;
      busy_set = 1'b0;
   endtask

   task automatic set_ra(input int p, input int a);
      raddr[p*AW +: AW] = AW'(a);
   endtask

   initial begin
      reset = 1'b1; raddr = '0; RegWrite = 1'b0; RD = '0;
      WriteData = '0; busy_set = 1'b0; busy_rd = '0;
      model_clear();
      #2;
      check_all("reset_hold");
      @(posedge clock); #1;
      reset = 1'b0;
      #1;
      check_all("reset_rel");

      // T1: write then mid-cycle async reset
      RegWrite = 1'b1; RD = 5; WriteData = 32'hDEADBEEF;
      busy_set = 1'b1; busy_rd = 8;
      tick();
      idle(); set_ra(0, 5); set_ra(1, 8); set_ra(2, 0);
      #1;
      check_all("t1_pre");
      chk("t1_rd5", rdata[31:0], 32'hDEADBEEF);
      #2;
      reset = 1'b1;
      model_clear();
      #1;
      chk("t1_rd5_rst", rdata[31:0], 32'h0);
      chk("t1_vec_rst", busy_vec, 32'h0);
      check_all("t1_rst");
      @(posedge clock); #1;
      reset = 1'b0;
      #1;
      check_all("t1_post");

      // T2: x0 stays zero and never pending
      RegWrite = 1'b1; RD = 0; WriteData = 32'hFFFFFFFF;
      busy_set = 1'b1; busy_rd = 0;
      set_ra(0, 0); set_ra(1, 0); set_ra(2, 0);
      #1;
      check_all("t2_same");
      tick();
      idle();
      #1;
      chk("t2_rd0", rdata[31:0], 32'h0);
      chk("t2_vec0", 32'(busy_vec[0]), 32'h0);
      check_all("t2_after");

      // T3: multiport reads
      RegWrite = 1'b1; RD = 3; WriteData = 32'h11;
      tick();
      RD = 7; WriteData = 32'h22;
      tick();
      idle();
      set_ra(0, 3); set_ra(1, 7); set_ra(2, 3);
      #1;
      chk("t3_p0", rdata[31:0], 32'h11);
      chk("t3_p1", rdata[63:32], 32'h22);
      chk("t3_p2", rdata[95:64], 32'h11);
      check_all("t3");

      // T4: scoreboard set then writeback clear
      busy_set = 1'b1; busy_rd = 9;
      tick();
      idle(); set_ra(0, 9);
      #1;
      chk("t4_busy", 32'(rbusy[0]), 32'h1);
      check_all("t4_set");
      RegWrite = 1'b1; RD = 9; WriteData = 32'h55;
      #1;
      check_all("t4_wr");
      tick();
      idle();
      #1;
      chk("t4_clr", 32'(rbusy[0]), 32'h0);
      chk("t4_data", rdata[31:0], 32'h55);

      // T5: set and clear of the same register on one edge
      busy_set = 1'b1; busy_rd = 12;
      tick();
      RegWrite = 1'b1; RD = 12; WriteData = 32'h77;
      busy_set = 1'b1; busy_rd = 12;
      set_ra(0, 12);
      #1;
      check_all("t5_same");
      tick();
      idle();
      #1;
      chk("t5_busy", 32'(busy_vec[12]), 32'h1);
      chk("t5_data", rdata[31:0], 32'h77);
      check_all("t5");

      // T6: same-cycle read of the register being written
      RegWrite = 1'b1; RD = 4; WriteData = 32'h1;
      tick();
      idle();
      RegWrite = 1'b1; RD = 4; WriteData = 32'h2;
      set_ra(0, 4);
      #1;
`ifdef RF_BYPASS_EN
      chk("t6_same", rdata[31:0], 32'h2);
`else
      chk("t6_same", rdata[31:0], 32'h1);
`endif
      tick();
      idle();
      #1;
      chk("t6_next", rdata[31:0], 32'h2);

      // Randomized traffic; narrow address range raises port collisions
      for (int n = 0; n < 400; n++) begin
         int hi;
         hi = ($urandom_range(0, 3) == 0) ? 31 : 7;
         RegWrite  = 1'($urandom_range(0, 1));
         RD        = AW'($urandom_range(0, hi));
         WriteData = $urandom;
         busy_set  = 1'($urandom_range(0, 1));
         busy_rd   = ($urandom_range(0, 2) == 0) ? RD
                                                 : AW'($urandom_range(0, hi));
         for (int p = 0; p < NUM_RD; p++)
            set_ra(p, ($urandom_range(0, 1) == 0) ? int'(RD)
                                                  : $urandom_range(0, hi));
         #1;
         check_all("rand");
         tick();
      end

      idle();
      #1;
      check_all("final");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
